// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch timekeeping core and the display scanner.
// The digits bus is {min_t, min_u, sec_t, sec_u, cs_t, cs_u}, one BCD nibble each.
package stopwatch_pkg;

  localparam int BCD_W    = 4;
  localparam int CS_MAX   = 99;
  localparam int SEC_MAX  = 59;
  localparam int DIGITS_W = 6 * BCD_W;

  // Bit offsets of each digit inside the digits bus
  localparam int CS_U_LSB  = 0;
  localparam int CS_T_LSB  = 4;
  localparam int SEC_U_LSB = 8;
  localparam int SEC_T_LSB = 12;
  localparam int MIN_U_LSB = 16;
  localparam int MIN_T_LSB = 20;

  // Highest value of each seconds/centiseconds digit
  localparam logic [BCD_W-1:0] CS_T_TOP  = BCD_W'(CS_MAX / 10);
  localparam logic [BCD_W-1:0] CS_U_TOP  = BCD_W'(CS_MAX % 10);
  localparam logic [BCD_W-1:0] SEC_T_TOP = BCD_W'(SEC_MAX / 10);
  localparam logic [BCD_W-1:0] SEC_U_TOP = BCD_W'(SEC_MAX % 10);

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_PAUSE = 2'd2;

  // Field order matches the digits bus, so a cast is bit-exact
  typedef struct packed {
    logic [BCD_W-1:0] min_t;
    logic [BCD_W-1:0] min_u;
    logic [BCD_W-1:0] sec_t;
    logic [BCD_W-1:0] sec_u;
    logic [BCD_W-1:0] cs_t;
    logic [BCD_W-1:0] cs_u;
  } bcd_time_t;

endpackage

// File: rtl/stopwatch_core_if.sv
// Button/tick inputs and display outputs of the stopwatch core.
// master = the board/bench side, slave = stopwatch_core.
interface stopwatch_core_if;
  import stopwatch_pkg::*;

  logic                tick_in;
  logic                btn_start;
  logic                btn_clear;
  logic                btn_lap;
  logic [DIGITS_W-1:0] digits;
  logic                running;
  logic                lap_hold;
  logic                wrap;

  modport master (
    output tick_in, btn_start, btn_clear, btn_lap,
    input  digits, running, lap_hold, wrap
  );

  modport slave (
    input  tick_in, btn_start, btn_clear, btn_lap,
    output digits, running, lap_hold, wrap
  );

endinterface

// File: rtl/stopwatch_core_sync_edge_detect.sv
// Synchroniser chain plus rising-edge detector producing a registered one-cycle pulse.
// Pulses are suppressed until the chain has refilled after reset, so a level that
// was already high when reset released is absorbed as history rather than an edge.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [SYNC_STAGES:0]   arm_q;

  // Shift the input through the synchroniser and flag new rising edges once armed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      arm_q  <= '0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      hist_q <= sync_q[SYNC_STAGES-1];
      arm_q  <= {arm_q[SYNC_STAGES-1:0], 1'b1};
      pulse  <= arm_q[SYNC_STAGES] & sync_q[SYNC_STAGES-1] & ~hist_q;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping core: counts MM:SS.cc in BCD from the 100 Hz tick,
// with run/pause/clear control and a lap snapshot that freezes the display.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_MIN     = 59
) (
  input logic             clk,
  input logic             rst_n,
  stopwatch_core_if.slave sw
);

  localparam logic [BCD_W-1:0] MIN_T_TOP = BCD_W'(MAX_MIN / 10);
  localparam logic [BCD_W-1:0] MIN_U_TOP = BCD_W'(MAX_MIN % 10);

  logic      tick_p, start_p, clear_p, lap_p;
  state_t    state_q, state_d;
  bcd_time_t live_q, live_d, live_inc;
  bcd_time_t snap_q, snap_d;
  bcd_time_t digits_q, digits_d;
  logic      lap_q, lap_d;
  logic      wrap_q, wrap_d;
  logic      running_q;
  logic      inc_wrap;

  // Cascaded BCD increment; the top bit reports the MAX_MIN:59.99 -> 0 roll-over
  function automatic logic [DIGITS_W:0] bcd_inc(input bcd_time_t t);
    bcd_time_t r;
    logic      wrapped;
    r       = t;
    wrapped = 1'b0;
    if (t.cs_u != CS_U_TOP) begin
      r.cs_u = t.cs_u + 4'd1;
    end else begin
      r.cs_u = '0;
      if (t.cs_t != CS_T_TOP) begin
        r.cs_t = t.cs_t + 4'd1;
      end else begin
        r.cs_t = '0;
        if (t.sec_u != SEC_U_TOP) begin
          r.sec_u = t.sec_u + 4'd1;
        end else begin
          r.sec_u = '0;
          if (t.sec_t != SEC_T_TOP) begin
            r.sec_t = t.sec_t + 4'd1;
          end else begin
            r.sec_t = '0;
            if (t.min_t == MIN_T_TOP && t.min_u == MIN_U_TOP) begin
              r.min_t = '0;
              r.min_u = '0;
              wrapped = 1'b1;
            end else if (t.min_u != 4'd9) begin
              r.min_u = t.min_u + 4'd1;
            end else begin
              r.min_u = '0;
              r.min_t = t.min_t + 4'd1;
            end
          end
        end
      end
    end
    return {wrapped, r};
  endfunction

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_tick (
    .clk(clk), .rst_n(rst_n), .d(sw.tick_in), .pulse(tick_p));
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_start (
    .clk(clk), .rst_n(rst_n), .d(sw.btn_start), .pulse(start_p));
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_clear (
    .clk(clk), .rst_n(rst_n), .d(sw.btn_clear), .pulse(clear_p));
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_lap (
    .clk(clk), .rst_n(rst_n), .d(sw.btn_lap), .pulse(lap_p));

  assign {inc_wrap, live_inc} = bcd_inc(live_q);

  // Next-state logic: clear beats everything; tick and lap act on the pre-transition state
  always_comb begin
    state_d = state_q;
    live_d  = live_q;
    snap_d  = snap_q;
    lap_d   = lap_q;
    wrap_d  = 1'b0;
    if (clear_p) begin
      state_d = ST_IDLE;
      live_d  = '0;
      snap_d  = '0;
      lap_d   = 1'b0;
    end else begin
      if (tick_p && state_q == ST_RUN) begin
        live_d = live_inc;
        wrap_d = inc_wrap;
      end
      if (lap_p && state_q == ST_RUN) begin
        lap_d = ~lap_q;
        if (!lap_q) begin
          snap_d = live_q;
        end
      end
      if (start_p) begin
        case (state_q)
          ST_IDLE:  state_d = ST_RUN;
          ST_RUN:   state_d = ST_PAUSE;
          ST_PAUSE: state_d = ST_RUN;
          default:  state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Display source: frozen snapshot while in lap hold, live count otherwise
  always_comb begin
    digits_d = lap_d ? snap_d : live_d;
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      live_q    <= '0;
      snap_q    <= '0;
      lap_q     <= 1'b0;
      wrap_q    <= 1'b0;
      digits_q  <= '0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      live_q    <= live_d;
      snap_q    <= snap_d;
      lap_q     <= lap_d;
      wrap_q    <= wrap_d;
      digits_q  <= digits_d;
      running_q <= (state_d == ST_RUN);
    end
  end

  assign sw.digits   = digits_q;
  assign sw.running  = running_q;
  assign sw.lap_hold = lap_q;
  assign sw.wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core: two instances share all stimulus, one with
// the default MAX_MIN and one with MAX_MIN=1 so the roll-over is reachable quickly.
// Expected digits are hand-computed BCD written as hex (MMSScc).
`timescale 1ns/100ps
module tb_stopwatch_core;
  import stopwatch_pkg::*;

  typedef struct {
    string       name;
    int          unit;
    logic [23:0] digits;
    logic        running;
    logic        lap_hold;
    int          wraps;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t exp_q[$];
  event check_ev;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   wrap_cnt0 = 0;
  int   wrap_cnt1 = 0;

  stopwatch_core_if sw0 ();
  stopwatch_core_if sw1 ();

  stopwatch_core #(.SYNC_STAGES(2), .MAX_MIN(59)) dut0 (
    .clk(clk), .rst_n(rst_n), .sw(sw0));
  stopwatch_core #(.SYNC_STAGES(2), .MAX_MIN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sw(sw1));

  // 100 MHz system clock
  always #5 clk = ~clk;

  // Count cycles with wrap high; a single clean pulse shows up as exactly one
  always @(negedge clk) begin
    if (sw0.wrap) wrap_cnt0++;
    if (sw1.wrap) wrap_cnt1++;
  end

  // Monitor: drain queued expectations whenever a sample point is announced
  initial begin
    forever begin
      @(check_ev);
      while (exp_q.size() > 0) begin
        exp_t        e;
        logic [23:0] ad;
        logic        ar, al;
        int          aw;
        e = exp_q.pop_front();
        if (e.unit == 0) begin
          ad = sw0.digits; ar = sw0.running; al = sw0.lap_hold; aw = wrap_cnt0;
        end else begin
          ad = sw1.digits; ar = sw1.running; al = sw1.lap_hold; aw = wrap_cnt1;
        end
        tests_run++;
        if (ad !== e.digits || ar !== e.running || al !== e.lap_hold || aw != e.wraps) begin
          tests_failed++;
          $display("[TB] FAIL %s (unit %0d): got digits=%h running=%b lap_hold=%b wraps=%0d, expected digits=%h running=%b lap_hold=%b wraps=%0d",
                   e.name, e.unit, ad, ar, al, aw, e.digits, e.running, e.lap_hold, e.wraps);
        end
      end
    end
  end

  task automatic apply_stimulus(input logic tick, input logic start,
                                input logic clear, input logic lap);
    sw0.tick_in = tick; sw0.btn_start = start; sw0.btn_clear = clear; sw0.btn_lap = lap;
    sw1.tick_in = tick; sw1.btn_start = start; sw1.btn_clear = clear; sw1.btn_lap = lap;
  endtask

  task automatic check_output(input string name, input int unit, input logic [23:0] digits,
                              input logic running, input logic lap_hold, input int wraps);
    exp_t e;
    e.name = name; e.unit = unit; e.digits = digits;
    e.running = running; e.lap_hold = lap_hold; e.wraps = wraps;
    exp_q.push_back(e);
    ->check_ev;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk); #1 apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1 apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic start, input logic clear, input logic lap);
    @(posedge clk); #1 apply_stimulus(1'b0, start, clear, lap);
    repeat (4) @(posedge clk);
    #1 apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_main", 0, 24'h000000, 1'b0, 1'b0, 0);
    check_output("reset_wrapdut", 1, 24'h000000, 1'b0, 1'b0, 0);

    // Run and count the basic 150 centiseconds
    press(1'b1, 1'b0, 1'b0);
    check_output("start_runs", 0, 24'h000000, 1'b1, 1'b0, 0);
    tick_n(150);
    check_output("count_150", 0, 24'h000150, 1'b1, 1'b0, 0);

    // Seconds-to-minutes carry
    tick_n(5849);
    check_output("count_5999", 0, 24'h005999, 1'b1, 1'b0, 0);
    tick_n(1);
    check_output("minute_carry", 0, 24'h010000, 1'b1, 1'b0, 0);
    check_output("minute_carry_w", 1, 24'h010000, 1'b1, 1'b0, 0);

    // Roll-over on the MAX_MIN=1 instance
    tick_n(5999);
    check_output("before_wrap", 1, 24'h015999, 1'b1, 1'b0, 0);
    tick_n(1);
    check_output("wrap_to_zero", 1, 24'h000000, 1'b1, 1'b0, 1);
    check_output("no_wrap_main", 0, 24'h020000, 1'b1, 1'b0, 0);

    // Lap freeze and release
    press(1'b0, 1'b1, 1'b0);
    check_output("clear_idle", 0, 24'h000000, 1'b0, 1'b0, 0);
    press(1'b1, 1'b0, 1'b0);
    tick_n(200);
    check_output("lap_pre", 0, 24'h000200, 1'b1, 1'b0, 0);
    press(1'b0, 1'b0, 1'b1);
    check_output("lap_enter", 0, 24'h000200, 1'b1, 1'b1, 0);
    tick_n(50);
    check_output("lap_frozen", 0, 24'h000200, 1'b1, 1'b1, 0);
    press(1'b0, 1'b0, 1'b1);
    check_output("lap_exit", 0, 24'h000250, 1'b1, 1'b0, 0);

    // Clear, start and tick together while running with lap hold set
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    tick_n(500);
    check_output("count_500", 0, 24'h000500, 1'b1, 1'b0, 0);
    press(1'b0, 1'b0, 1'b1);
    check_output("lap_at_500", 0, 24'h000500, 1'b1, 1'b1, 0);
    @(posedge clk); #1 apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1 apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check_output("simul_clear", 0, 24'h000000, 1'b0, 1'b0, 0);
    tick_n(3);
    check_output("idle_no_count", 0, 24'h000000, 1'b0, 1'b0, 0);

    // Pause holds the count; resume then a tick three cycles later
    press(1'b1, 1'b0, 1'b0);
    tick_n(321);
    check_output("count_321", 0, 24'h000321, 1'b1, 1'b0, 0);
    press(1'b1, 1'b0, 1'b0);
    check_output("paused", 0, 24'h000321, 1'b0, 1'b0, 0);
    tick_n(20);
    check_output("pause_ticks", 0, 24'h000321, 1'b0, 1'b0, 0);
    press(1'b0, 1'b0, 1'b1);
    check_output("pause_lap_ign", 0, 24'h000321, 1'b0, 1'b0, 0);
    @(posedge clk); #1 apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1 apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1 apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check_output("resume_tick", 0, 24'h000322, 1'b1, 1'b0, 0);

    // Asynchronous reset mid-count, start held high across release
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    tick_n(777);
    check_output("count_777", 0, 24'h000777, 1'b1, 1'b0, 0);
    @(posedge clk);
    #1 apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #0.5;
    check_output("async_reset", 0, 24'h000000, 1'b0, 1'b0, 0);
    check_output("async_reset_w", 1, 24'h000000, 1'b0, 1'b0, 1);
    #0.5 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check_output("held_start_ign", 0, 24'h000000, 1'b0, 1'b0, 0);
    press(1'b1, 1'b0, 1'b0);
    tick_n(1);
    check_output("post_reset_run", 0, 24'h000001, 1'b1, 1'b0, 0);

    repeat (10) @(posedge clk);
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Timekeeping core of the stopwatch: consumes the 100 Hz square wave produced by the clock divider as a sampled data input (never as a clock), and counts elapsed time in BCD as MM:SS.cc. Start/stop, clear and lap buttons (already debounced upstream) are synchronised and edge-detected here. The six-digit BCD output feeds the seven-segment scan/refresh stage.

## Interface
Parameters:
- SYNC_STAGES, 2, synchroniser flops on tick_in and each button input (min 2)
- MAX_MIN, 59, highest minutes value before wrap (0..99)

Ports:
- clk  in  1  system clock; the only clock in the block
- rst_n  in  1  reset, asynchronous, active-low
- tick_in  in  1  100 Hz square wave from clk_divider; each rising edge = 1 centisecond
- btn_start  in  1  level, high while pressed; rising edge toggles run/pause
- btn_clear  in  1  level; rising edge zeroes count and exits lap hold
- btn_lap  in  1  level; rising edge toggles lap hold (display freeze)
- digits  out  24  {min_t, min_u, sec_t, sec_u, cs_t, cs_u}, 4-bit BCD each
- running  out  1  high in RUN state
- lap_hold  out  1  high while digits shows a frozen snapshot
- wrap  out  1  one-cycle pulse when count rolls MAX_MIN:59.99 -> 00:00.00

## Operation
- Each input passes through SYNC_STAGES flops, then a rising-edge detector giving a one-cycle pulse: tick_p, start_p, clear_p, lap_p.
- FSM states: IDLE (count zero, not running), RUN, PAUSE.
  - IDLE: start_p -> RUN.
  - RUN: start_p -> PAUSE; clear_p -> IDLE.
  - PAUSE: start_p -> RUN; clear_p -> IDLE.
- Counting: tick_p increments the live count only when the current (registered) state is RUN. cs 00..99, sec 00..59, min 00..MAX_MIN; every digit is pure BCD, never holds A..F.
- Roll-over: at MAX_MIN:59.99 a tick gives 00:00.00, wrap=1 for that cycle, state stays RUN.
- Lap: lap_p in RUN toggles lap_hold. On entry the live count is copied to a snapshot register; while lap_hold=1 digits shows the snapshot and the live count keeps running. lap_p in IDLE or PAUSE is ignored, but lap_hold, once set, persists through PAUSE.
- Clear: clear_p zeroes the live count and snapshot, clears lap_hold, goes to IDLE, from any state.
- Simultaneous pulses in one cycle: clear_p has priority over everything (tick and start ignored). start_p together with tick_p: the tick is applied per the state before the transition (RUN->PAUSE counts it; PAUSE->RUN does not). lap_p together with tick_p in RUN: the snapshot captures the pre-increment value.
- Reset: digits=0, running=0, lap_hold=0, wrap=0, state IDLE, synchroniser and edge-detect history cleared to 0. An input already high when reset releases produces no pulse.

## Timing
- Input edge to pulse: SYNC_STAGES+1 clk cycles. With the default, a tick_in rise sampled at edge N updates the live count at edge N+3.
- digits, running, lap_hold and wrap are registered. running changes on the same edge as the state register; wrap goes high on the edge where the count becomes zero.
- Each pulse is exactly one cycle wide regardless of how long the input stays high.
- Reset asserted mid-count takes effect immediately (asynchronous), with no partial update. Release is synchronous to clk through the usual reset-release path.

## Structure
- Package stopwatch_pkg: state enum (IDLE, RUN, PAUSE), BCD_W=4, CS_MAX=99, SEC_MAX=59, and the digits bus field order/offsets shared with the display scanner.
- Sub-module sync_edge_detect (parameter SYNC_STAGES; ports clk, rst_n, d, pulse), instantiated four times.
- Cascaded BCD counter, snapshot register and FSM stay in stopwatch_core.

## Test plan
- Reset then btn_start; 150 tick_in rises -> digits = 00:01.50, running=1, no wrap pulse.
- Preload to 00:59.99 via ticks, one more tick -> 01:00.00; with MAX_MIN=59, from 59:59.99 one tick -> 00:00.00 and wrap high exactly one cycle.
- RUN at 00:02.00, btn_lap -> digits frozen at 00:02.00 while 50 more ticks occur; second btn_lap -> digits = 00:02.50.
- btn_start, btn_clear and tick_in rising in the same cycle while RUN at 00:05.00 -> IDLE, digits 00:00.00, running=0, lap_hold=0.
- PAUSE at 00:03.21, 20 ticks -> digits unchanged; btn_start, then a tick 3 cycles later -> 00:03.22.
- rst_n low for 1 ns mid-count at 00:07.77 -> all outputs 0 immediately; btn_start held high across reset release -> stays IDLE.
